// File: rtl/ex_result_demux2.sv
// ex_result_demux2
// Routes one execute-stage result stream to two independently back-pressured
// destinations (A: GPR write-back, B: HI/LO / special registers). Each
// destination owns a small FIFO so a stalled consumer only blocks the other
// once its own FIFO is full.
module ex_result_demux2 #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic                     in_sel,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     in_ready,
  output logic                     a_valid,
  output logic [WIDTH-1:0]         a_data,
  input  logic                     a_ready,
  output logic                     b_valid,
  output logic [WIDTH-1:0]         b_data,
  input  logic                     b_ready,
  output logic [$clog2(DEPTH):0]   a_count,
  output logic [$clog2(DEPTH):0]   b_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // Per-destination views, index 0 = A, index 1 = B.
  logic [1:0]            push_w;
  logic [1:0]            pop_w;
  logic [1:0]            valid_w;
  logic [1:0]            ready_w;
  logic [1:0][CW-1:0]    count_w;
  logic [1:0][WIDTH-1:0] head_w;
  logic                  accept_w;

  assign ready_w = {b_ready, a_ready};

  // Ready depends only on registered occupancy, so the upstream stage never
  // sees a combinational loop through valid/select/data.
  assign in_ready = (count_w[0] != FULL) && (count_w[1] != FULL);

  // A flush cycle swallows any offered input.
  assign accept_w = in_valid & in_ready & ~flush;

  for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    wptr_d;
    logic [AW-1:0]    rptr_q;
    logic [AW-1:0]    rptr_d;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;

    assign valid_w[gi] = (count_q != '0);
    assign push_w[gi]  = accept_w & (in_sel == 1'(gi));
    assign pop_w[gi]   = valid_w[gi] & ready_w[gi] & ~flush;
    assign count_w[gi] = count_q;
    // Head is read combinationally so a pushed word is visible the next cycle.
    assign head_w[gi]  = mem_q[rptr_q];

    // Next-state pointers and occupancy; flush overrides any handshake.
    always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (flush) begin
        wptr_d  = '0;
        rptr_d  = '0;
        count_d = '0;
      end else begin
        // DEPTH is a power of two, so natural overflow gives the wrap-around.
        if (push_w[gi]) wptr_d = wptr_q + AW'(1);
        if (pop_w[gi])  rptr_d = rptr_q + AW'(1);
        case ({push_w[gi], pop_w[gi]})
          2'b10:   count_d = count_q + CW'(1);
          2'b01:   count_d = count_q - CW'(1);
          default: count_d = count_q;
        endcase
      end
    end

    // State registers and storage; storage is cleared on reset so the head
    // output is a defined zero rather than X before the first push.
    always_ff @(posedge clk) begin
      if (rst) begin
        wptr_q  <= '0;
        rptr_q  <= '0;
        count_q <= '0;
        for (int i = 0; i < DEPTH; i++) begin
          mem_q[i] <= '0;
        end
      end else begin
        wptr_q  <= wptr_d;
        rptr_q  <= rptr_d;
        count_q <= count_d;
        if (push_w[gi]) begin
          mem_q[wptr_q] <= in_data;
        end
      end
    end
  end

  assign a_valid = valid_w[0];
  assign a_data  = head_w[0];
  assign a_count = count_w[0];
  assign b_valid = valid_w[1];
  assign b_data  = head_w[1];
  assign b_count = count_w[1];

endmodule
